// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction-address/word widths and the fetch buffer entry.
package cpu_pkg;

  localparam int IADDR_W = 9;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [IADDR_W-1:0] pc;
  } fifo_entry_t;

  // Word-address increment; 511 wraps to 0 through the natural width.
  function automatic logic [IADDR_W-1:0] pc_next(input logic [IADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: instruction-cache port, fetch-to-decode handshake and redirect.
interface ifetch_unit_if;
  import cpu_pkg::*;

  logic [IADDR_W-1:0] addr;
  logic [INSTR_W-1:0] instr;
  // Transfer happens on a rising edge where if_valid && id_ready; if_valid never
  // waits on id_ready, and if_instr/if_pc stay stable while if_valid && !id_ready.
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [IADDR_W-1:0] if_pc;
  logic               id_ready;
  logic               redirect_valid;
  logic [IADDR_W-1:0] redirect_pc;
  logic               halted;

  modport master (
    output addr, if_valid, if_instr, if_pc, halted,
    input  instr, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  addr, if_valid, if_instr, if_pc, halted,
    output instr, id_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry fetch buffer with synchronous flush; flush wins over push and pop.
module ifetch_fifo
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  fifo_entry_t i_push_data,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic [1:0]  o_count
);

  fifo_entry_t r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_do_pop;

  assign w_do_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Single-issue instruction fetch with 2-entry buffer, redirect and halt address.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [IADDR_W-1:0] RESET_PC  = 9'd0,
  parameter logic [IADDR_W-1:0] HALT_ADDR = 9'd249
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef IFETCH_PERF_EN
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall,
`endif
  ifetch_unit_if.master bus
);

  logic [IADDR_W-1:0] r_pc;
  logic [IADDR_W-1:0] r_inflight_pc;
  logic               r_inflight;
  logic               r_halted;

  logic [1:0]  w_count;
  logic [2:0]  w_occ;
  logic        w_valid;
  logic        w_pop;
  logic        w_room;
  logic        w_would_issue;
  logic        w_issue;
  fifo_entry_t w_head;
  fifo_entry_t w_push_data;

  assign w_valid = (w_count != 2'd0);
  assign w_pop   = w_valid && bus.id_ready;

  // A pop this cycle frees its slot before the next push lands, which is what
  // lets the unit sustain one instruction per cycle with only two entries.
  assign w_occ         = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room        = (w_occ < 3'd2);
  assign w_would_issue = !r_halted && !bus.redirect_valid && w_room;
  assign w_issue       = w_would_issue && (r_pc != HALT_ADDR);

  assign w_push_data = '{instr: bus.instr, pc: r_inflight_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_halted      <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= pc_next(r_pc);
      end
      if (w_would_issue && (r_pc == HALT_ADDR)) r_halted <= 1'b1;
    end
  end

  ifetch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (bus.redirect_valid),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign bus.addr     = r_pc;
  assign bus.if_valid = w_valid;
  assign bus.if_instr = w_head.instr;
  assign bus.if_pc    = w_head.pc;
  assign bus.halted   = r_halted;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_valid && !bus.id_ready && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected fetches queued by stimulus, checked by a monitor.
module tb_ifetch_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;

  ifetch_unit_if bus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  ifetch_unit #(
    .RESET_PC  (9'd0),
    .HALT_ADDR (9'd249)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef IFETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
`endif
    .bus          (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] instr_of(input logic [8:0] a);
    return {7'h5a, a, 16'hc0de ^ {7'h00, a}};
  endfunction

  logic [31:0] ram [512];
  initial for (int i = 0; i < 512; i++) ram[i] = instr_of(9'(i));
  always @(posedge clk) bus.instr <= ram[bus.addr];

  // ---------------- scoreboard ----------------
  logic [40:0] exp_q [$];
  logic [40:0] mon_exp;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_run(input logic [8:0] start, input int n);
    logic [8:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({instr_of(a), a});
      a = a + 9'd1;
    end
  endtask

  // Monitor: a handshake seen at a falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.if_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %0d instr %0h, nothing expected", bus.if_pc, bus.if_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_fetch", {bus.if_instr, bus.if_pc}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Accept exactly n instructions, counting the cycles that offered nothing.
  task automatic take(input int n, output int gaps);
    int got;
    int budget;
    got    = 0;
    budget = 0;
    gaps   = 0;
    bus.id_ready = 1'b1;
    while (got < n && budget < 64) begin
      @(negedge clk);
      if (bus.if_valid) got++;
      else gaps++;
      budget++;
      @(posedge clk); #1;
    end
    bus.id_ready = 1'b0;
    n_cmp++;
    if (got != n) begin
      n_err++;
      $display("FAIL take_timeout: got %0d of %0d", got, n);
    end
  endtask

  task automatic redirect(input logic [8:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int gaps;

  initial begin
    rst_n              = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_valid", 41'(bus.if_valid), 41'd0);
    check("rst_if_pc",    41'(bus.if_pc),    41'd0);
    check("rst_if_instr", 41'(bus.if_instr), 41'd0);
    check("rst_addr",     41'(bus.addr),     41'd0);
    check("rst_halted",   41'(bus.halted),   41'd0);

    // Reset release: 0,1,2 back to back, first valid two cycles after release.
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_run(9'd0, 3);
    take(3, gaps);
    check("start_latency", 41'(gaps), 41'd2);

    // Decode stalls with pc 3 at the head; pc 4 lands in the buffer, pc 5 waits.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_if_valid", 41'(bus.if_valid), 41'd1);
      check("stall_if_pc",    41'(bus.if_pc),    41'd3);
      check("stall_addr",     41'(bus.addr),     41'd5);
      @(posedge clk); #1;
    end
    expect_run(9'd3, 3);
    take(3, gaps);
    check("stall_resume_gaps", 41'(gaps), 41'd0);

    // Redirect with two entries buffered (6 and 7): they must never appear.
    @(posedge clk); #1;
    redirect(9'd27);
    expect_run(9'd27, 2);
    take(2, gaps);
    check("redirect27_latency", 41'(gaps), 41'd2);

    // Redirect with one buffered and one in flight, landing on the wrap point.
    redirect(9'd510);
    expect_run(9'd510, 4);
    take(4, gaps);
    check("wrap_latency", 41'(gaps), 41'd2);

    // Run into HALT_ADDR: 245..248 delivered, then nothing.
    redirect(9'd245);
    expect_run(9'd245, 4);
    take(4, gaps);
    check("halt_run_latency", 41'(gaps), 41'd2);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_halted",   41'(bus.halted),   41'd1);
      check("halt_addr",     41'(bus.addr),     41'd249);
      check("halt_if_valid", 41'(bus.if_valid), 41'd0);
      @(posedge clk); #1;
    end
    bus.id_ready = 1'b0;
    redirect(9'd0);
    check("halt_cleared", 41'(bus.halted), 41'd0);
    expect_run(9'd0, 2);
    take(2, gaps);
    check("resume_latency", 41'(gaps), 41'd2);

    // Mid-stream reset: buffer is full, reset must empty it immediately.
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_valid", 41'(bus.if_valid), 41'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_if_valid", 41'(bus.if_valid), 41'd0);
    check("midrst_if_pc",    41'(bus.if_pc),    41'd0);
    check("midrst_if_instr", 41'(bus.if_instr), 41'd0);
    check("midrst_addr",     41'(bus.addr),     41'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_run(9'd0, 3);
    take(3, gaps);
    check("restart_latency", 41'(gaps), 41'd2);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 41'(exp_q.size()), 41'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
